// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// All eight operations share one 2*XLEN shift register and one adder/subtractor.
// The multiply is radix-2 shift-add. The divide is restoring division.
// Divide-by-zero and signed-overflow divides skip CALC and go straight to FIN.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   request, sampled only while idle
//   funct3  in   [2:0] M-extension operation select
//   op_a    in   [XLEN-1:0] rs1 (multiplicand / dividend)
//   op_b    in   [XLEN-1:0] rs2 (multiplier / divisor)
//   busy    out  operation in flight
//   done    out  one-cycle pulse, result valid
//   result  out  [XLEN-1:0] final value, held between operations
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned AW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, next_state;

    // Datapath registers.
    // acc holds {product_hi, product_lo/multiplier} when multiplying.
    // It holds {remainder, quotient} when dividing.
    // dvs holds the multiplicand magnitude or the divisor magnitude.
    logic [2:0]       fn,   fn_d;
    logic [XLEN-1:0]  dvs,  dvs_d;
    logic [AW-1:0]    acc,  acc_d;
    logic             neg,  neg_d;
    logic [CNT_W-1:0] cnt,  cnt_d;
    logic             busy_d, done_d;
    logic [XLEN-1:0]  result_d;

    // Accept-time decode of operand signedness, magnitudes and special cases.
    logic            a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        mag_a    = sa ? (~op_a + XLEN'(1)) : op_a;
        mag_b    = sb ? (~op_b + XLEN'(1)) : op_b;
        is_div   = funct3[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        special  = div_zero || div_ovf;
    end

    // One iteration of each algorithm.
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    logic [XLEN:0]   div_hi;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [AW-1:0]   div_next;

    always_comb begin
        // Add the multiplicand into the high half if the current multiplier bit is set, then shift right.
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // The shifted partial remainder needs XLEN+1 bits because its top bit can be set.
        div_hi   = acc[AW-1:XLEN-1];
        div_ge   = div_hi >= {1'b0, dvs};
        // The true difference is below 2^XLEN whenever div_ge is set, so XLEN bits suffice.
        div_diff = div_hi[XLEN-1:0] - dvs;
        div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[AW-2:0], 1'b0};
    end

    // Sign fix and result selection for the FIN cycle.
    logic [AW-1:0]   prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, fin_val;

    always_comb begin
        prod_fix = neg ? (~acc + AW'(1)) : acc;
        quot_fix = neg ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
        rem_fix  = neg ? (~acc[AW-1:XLEN] + XLEN'(1)) : acc[AW-1:XLEN];
        case (fn)
            3'b000:                 fin_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_fix[AW-1:XLEN];
            3'b100, 3'b101:         fin_val = quot_fix;
            default:                fin_val = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = special ? FIN : CALC;
            CALC: if (cnt == CNT_W'(XLEN - 1)) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        fn_d     = fn;
        dvs_d    = dvs;
        acc_d    = acc;
        neg_d    = neg;
        cnt_d    = cnt;
        result_d = result;
        busy_d   = (next_state != IDLE);
        done_d   = (state == FIN);
        case (state)
            IDLE: begin
                if (start) begin
                    fn_d  = funct3;
                    cnt_d = '0;
                    if (div_zero) begin
                        // Quotient becomes all ones, and the remainder becomes the dividend.
                        acc_d = {op_a, {XLEN{1'b1}}};
                        dvs_d = op_b;
                        neg_d = 1'b0;
                    end else if (div_ovf) begin
                        // Quotient becomes the dividend, and the remainder becomes zero.
                        acc_d = {{XLEN{1'b0}}, op_a};
                        dvs_d = op_b;
                        neg_d = 1'b0;
                    end else begin
                        neg_d = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
                        if (is_div) begin
                            dvs_d = mag_b;
                            acc_d = {{XLEN{1'b0}}, mag_a};
                        end else begin
                            dvs_d = mag_a;
                            acc_d = {{XLEN{1'b0}}, mag_b};
                        end
                    end
                end
            end
            CALC: begin
                cnt_d = cnt + CNT_W'(1);
                acc_d = fn[2] ? div_next : mul_next;
            end
            FIN: begin
                result_d = fin_val;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fn     <= '0;
            dvs    <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            fn     <= fn_d;
            dvs    <= dvs_d;
            acc    <= acc_d;
            neg    <= neg_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            done   <= done_d;
            result <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN = 32).
// Expected results and latencies are queued when an operation is issued.
// They are checked when done pulses.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int NORM_LAT = XLEN + 2;
    localparam int SPEC_LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the M-extension semantics.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, p;
        logic [63:0]        ua64, ub64;
        logic [31:0]        r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        r    = '0;
        case (f)
            3'd0: begin p = ua64 * ub64;          r = p[31:0];  end
            3'd1: begin p = sa64 * sb64;          r = p[63:32]; end
            3'd2: begin p = sa64 * $signed(ub64); r = p[63:32]; end
            3'd3: begin p = ua64 * ub64;          r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'($signed(a) / $signed(b));
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'($signed(a) % $signed(b));
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic spec;
        spec = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return spec ? SPEC_LAT : NORM_LAT;
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] res, input int lat);
        exp_t it;
        it.tag     = tag;
        it.res     = res;
        it.lat     = lat;
        it.acc_cyc = cyc + 1;
        sb.push_back(it);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one operation at a negedge. The accept edge is the following posedge.
    // The inputs are scrambled once the operation has been accepted.
    task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        wait_idle();
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        push_exp(tag, exp, ref_lat(f, a, b));
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: count edges, and check each done pulse against the scoreboard.
    always @(posedge clk) begin
        exp_t it;
        cyc++;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                check_eq({it.tag, "_result"}, result, it.res);
                check_eq({it.tag, "_latency"}, 32'(cyc - it.acc_cyc + 1), 32'(it.lat));
                check_eq({it.tag, "_busy_at_done"}, 32'(busy), 32'd0);
                check_eq({it.tag, "_busy_cycles"}, 32'(busy_run), 32'(it.lat - 1));
            end
        end
        if (busy) busy_run++;
        else      busy_run = 0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          n;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_result", result, 32'd0);
        rst = 1'b0;

        // Multiply forms
        issue("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        issue("mulh_min",     3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        issue("mulhu_ones",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue("mulhsu_ones",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("mul_zero",     3'b000, 32'd0,          32'd12345,     32'd0);
        // Divide forms
        issue("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        issue("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        issue("divu_100_7",   3'b101, 32'd100,        32'd7,         32'd14);
        issue("remu_100_7",   3'b111, 32'd100,        32'd7,         32'd2);
        // Fast-path special cases
        issue("divu_by0",     3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
        issue("rem_by0",      3'b110, 32'd5,          32'd0,         32'd5);
        issue("div_by0",      3'b100, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF);
        issue("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        issue("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        drain();

        // start is held high: the second operation is accepted in the done cycle.
        @(negedge clk);
        wait_idle();
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd4;
        start  = 1'b1;
        push_exp("b2b_first", 32'd12, NORM_LAT);
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        push_exp("b2b_second", 32'd12, NORM_LAT);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset at edge E10 of a DIVU aborts the operation silently.
        @(negedge clk);
        wait_idle();
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd7;
        start  = 1'b1;
        c0     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        issue("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3);
        drain();

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd5;
        op_b   = 32'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("rst_start_busy", 32'(busy), 32'd0);
        check_eq("rst_start_result", result, 32'd0);
        repeat (40) @(negedge clk);

        // Random operations checked against the reference model.
        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 6 == 5) rb = 32'($urandom_range(1, 255));
            issue($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_res(rf, ra, rb));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RISC-V M extension. It is the parametrised, multi-cycle successor to the combinational ALU control path. It sits beside the ALU in the execute stage. The control unit pulses `start` with `funct3` and both operands, holds the pipeline while `busy` is high, and captures `result` when `done` pulses. All eight M-extension operations run on one shared shift/add-subtract datapath. Divide-by-zero and signed overflow take a fast path.

## Interface
- `XLEN`, 32, operand/result width; even, ≥ 4.
- `CNT_W`, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (multiplicand/dividend).
- `op_b`  in  XLEN  rs2 value (multiplier/divisor).
- `busy`  out  1  operation in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse; `result` is valid this cycle.
- `result`  out  XLEN  final value; held until the next accepted `start`.

## Operation
- States:
  - IDLE
  - CALC (XLEN iterations)
  - FIN (sign fix and result register)
- Accept: at an edge with state=IDLE and `start`=1, the unit latches `funct3`, the operand magnitudes, and the result sign. It clears the counter.
  - Normal case: go to CALC.
  - Special case: go directly to FIN.
- Operand signedness:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - Magnitude = two's-complement negate if signed and MSB=1.
- Result sign:
  - MUL*: sign(a) XOR sign(b).
  - DIV: sign(a) XOR sign(b).
  - REM: sign(a).
  - Unsigned ops: positive.
- CALC multiply: radix-2 shift-add into a 2·XLEN product register, one multiplier bit per cycle, LSB first.
- CALC divide: restoring division. Shift {rem,quot} left, trial-subtract the divisor, set the quotient bit if no borrow. One bit per cycle.
- The counter increments each CALC cycle. After the XLEN-th iteration (counter = XLEN-1 at the edge), go to FIN.
- FIN:
  - Negate the selected value if the result sign is negative.
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register into `result`, pulse `done`, return to IDLE.
- Special cases, decided at accept (RISC-V defined values, no trap):
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → op_a.
  - DIV with op_a = 1<<(XLEN-1) and op_b = all ones: result = op_a. The matching REM → 0.
  - MUL with either operand 0 is NOT special-cased; it takes full latency.
- `start` while `busy`=1 is ignored, with no effect on the operation in flight.
- `funct3`/operand changes after accept have no effect.

## Timing
- Reset values:
  - state = IDLE.
  - `busy` = 0, `done` = 0, `result` = 0.
  - Counter and datapath registers = 0.
- `busy` = 1 in every cycle where state ≠ IDLE. It rises the cycle after the accept edge and falls in the same cycle `done` rises.
- Normal latency: the accept edge is E0. CALC edges are E1..E_XLEN. The FIN edge E_XLEN+1 registers `result`. `done` is high for exactly the one cycle after E_XLEN+1, which is XLEN+2 edges after accept (34 for XLEN=32).
- Special-case latency: `done` is high the cycle after E1 (2 edges).
- Back-to-back: `start` may be high in the `done` cycle (state=IDLE). It is accepted at that edge, with no bubble.
- `rst` mid-operation: at the next edge the unit returns to IDLE and drops `busy`. No `done` is issued. `result` is cleared to 0.
- Simultaneous `rst` and `start`: reset wins; `start` is not accepted.

## Test plan
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD (-3) → `result`=0xFFFFFFEB. `done` pulses exactly 34 edges after the accept edge. `busy` is high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with `done` 2 edges after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, also 2 edges.
- `start`=1 held throughout a MUL 3×4: the second operation is not accepted until the `done` cycle. Result sequence is 12, then 12, with zero idle cycles between operations.
- Assert `rst` for one cycle at edge E10 of a DIVU: `busy`=0, `done` never pulses, `result`=0. A following DIVU 9/3 → 3 with normal latency.
